// File: rtl/cim_pkg.sv
// cim_pkg: shared types and constants for the compute-in-memory input path.
// Holds the loader FSM state encoding and the frame-count width.
package cim_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int FRAME_COUNT_W = 16;

endpackage

// File: rtl/inp_loader.sv
// inp_loader: gathers fifo_length elements into the input buffer, then fires one compute-start pulse.
// Optional INP_LOADER_FRAME_COUNT_EN adds a 16-bit count of completed frames.
module inp_loader
    import cim_pkg::*;
#(
    parameter int datatype_size = 8,
    parameter int fifo_length   = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [datatype_size-1:0] i_data,
    output logic                     o_write_enable,
    output logic [datatype_size-1:0] o_data,
    output logic                     o_start,
    input  logic                     i_done,
    output logic                     o_busy
`ifdef INP_LOADER_FRAME_COUNT_EN
    ,
    output logic [FRAME_COUNT_W-1:0] o_frame_count
`endif
);

    localparam int CNT_W = $clog2(fifo_length + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        o_ready        = (state == LOAD);
        o_write_enable = i_valid && o_ready;
        o_data         = i_data;
        o_start        = (state == START);
        o_busy         = (state != LOAD);
        // The final element of a frame both clears the counter and launches START on one edge.
        last           = o_write_enable && (cnt == CNT_W'(fifo_length - 1));
        cnt_nxt        = last ? '0 : o_write_enable ? cnt + 1'b1 : cnt;
        state_nxt      = state;
        case (state)
            LOAD:    state_nxt = last ? START : LOAD;
            START:   state_nxt = WAIT;
            WAIT:    state_nxt = i_done ? LOAD : WAIT;
            default: state_nxt = LOAD;
        endcase
    end

`ifdef INP_LOADER_FRAME_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            o_frame_count <= '0;
        else if (state == WAIT && i_done)
            o_frame_count <= o_frame_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_inp_loader.sv
// tb_inp_loader: table-driven and directed checks of inp_loader (fifo_length = 5).
module tb_inp_loader;

    localparam int DW = 8;
    localparam int FL = 5;

    logic          clk = 1'b0;
    logic          rst, i_valid, i_done;
    logic [DW-1:0] i_data, o_data;
    logic          o_ready, o_write_enable, o_start, o_busy;
`ifdef INP_LOADER_FRAME_COUNT_EN
    logic [15:0]   o_frame_count;
`endif

    always #5 clk = ~clk;

    inp_loader #(.datatype_size(DW), .fifo_length(FL)) dut (
        .clk(clk),
        .rst(rst),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_data(i_data),
        .o_write_enable(o_write_enable),
        .o_data(o_data),
        .o_start(o_start),
        .i_done(i_done),
        .o_busy(o_busy)
`ifdef INP_LOADER_FRAME_COUNT_EN
        ,
        .o_frame_count(o_frame_count)
`endif
    );

    typedef struct {
        logic          r, v;
        logic [DW-1:0] d;
        logic          dn;
        logic          er, ew;
        logic [DW-1:0] ed;
        logic          es, eb;
    } vec_t;

    vec_t tbl[21];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   writes;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later, well clear of posedge.
    task automatic drive(input logic r, input logic v, input logic [DW-1:0] d, input logic dn);
        @(negedge clk);
        rst = r; i_valid = v; i_data = d; i_done = dn;
        #1;
    endtask

    task automatic fill(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, DW'(base + i), 1'b0);
            chk("fill_we", {31'd0, o_write_enable}, 32'd1);
            chk("fill_data", {24'd0, o_data}, 32'(DW'(base + i)));
        end
    endtask

    task automatic frame();
        fill(FL, 8'h40);
        drive(1'b0, 1'b0, 8'h0, 1'b0);
        chk("frame_start", {31'd0, o_start}, 32'd1);
        drive(1'b0, 1'b0, 8'h0, 1'b1);
        chk("frame_wait_busy", {31'd0, o_busy}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_data = '0; i_done = 1'b0;
        //                r  v  d      dn   rdy we data   st bsy
        tbl[0]  = '{1'b0, 1'b1, 8'd1,  1'b0, 1'b1, 1'b1, 8'd1,  1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'd2,  1'b0, 1'b1, 1'b1, 8'd2,  1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'd3,  1'b0, 1'b1, 1'b1, 8'd3,  1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'd4,  1'b0, 1'b1, 1'b1, 8'd4,  1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'd5,  1'b0, 1'b1, 1'b1, 8'd5,  1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'd6,  1'b0, 1'b0, 1'b0, 8'd6,  1'b1, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 8'd6,  1'b0, 1'b0, 1'b0, 8'd6,  1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 8'd6,  1'b0, 1'b0, 1'b0, 8'd6,  1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 8'd6,  1'b1, 1'b0, 1'b0, 8'd6,  1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 8'd7,  1'b0, 1'b1, 1'b1, 8'd7,  1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 8'd8,  1'b1, 1'b1, 1'b1, 8'd8,  1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 8'd8,  1'b1, 1'b1, 1'b0, 8'd8,  1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 8'd9,  1'b0, 1'b1, 1'b1, 8'd9,  1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 8'd9,  1'b0, 1'b1, 1'b0, 8'd9,  1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 8'd10, 1'b0, 1'b1, 1'b1, 8'd10, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 8'd11, 1'b0, 1'b1, 1'b1, 8'd11, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 8'd0,  1'b1, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b1};
        tbl[18] = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b1};
        tbl[19] = '{1'b1, 1'b1, 8'd1,  1'b0, 1'b1, 1'b1, 8'd1,  1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0};

        drive(1'b1, 1'b0, 8'h0, 1'b0);
        drive(1'b1, 1'b0, 8'h0, 1'b1);
        drive(1'b0, 1'b0, 8'h0, 1'b0);
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_start", {31'd0, o_start}, 32'd0);
        chk("rst_we", {31'd0, o_write_enable}, 32'd0);

        // Frame of 1..5, WAIT with done ignored in LOAD/START, then rst beating a handshake.
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].dn);
            chk($sformatf("v%0d_ready", i), {31'd0, o_ready}, {31'd0, tbl[i].er});
            chk($sformatf("v%0d_we", i), {31'd0, o_write_enable}, {31'd0, tbl[i].ew});
            chk($sformatf("v%0d_data", i), {24'd0, o_data}, {24'd0, tbl[i].ed});
            chk($sformatf("v%0d_start", i), {31'd0, o_start}, {31'd0, tbl[i].es});
            chk($sformatf("v%0d_busy", i), {31'd0, o_busy}, {31'd0, tbl[i].eb});
        end

        // Long WAIT with the producer holding valid, then release.
        fill(FL, 8'h10);
        drive(1'b0, 1'b1, 8'hAA, 1'b0);
        chk("hold_start", {31'd0, o_start}, 32'd1);
        chk("hold_start_we", {31'd0, o_write_enable}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 8'hAA, 1'b0);
            chk("hold_we", {31'd0, o_write_enable}, 32'd0);
            chk("hold_ready", {31'd0, o_ready}, 32'd0);
        end
        drive(1'b0, 1'b1, 8'hAA, 1'b1);
        chk("hold_done_we", {31'd0, o_write_enable}, 32'd0);
        drive(1'b0, 1'b1, 8'hAA, 1'b0);
        chk("hold_ready_back", {31'd0, o_ready}, 32'd1);
        chk("hold_first_we", {31'd0, o_write_enable}, 32'd1);
        chk("hold_first_data", {24'd0, o_data}, 32'hAA);
        fill(FL - 1, 8'h20);
        drive(1'b0, 1'b0, 8'h0, 1'b0);
        chk("hold_frame2_start", {31'd0, o_start}, 32'd1);
        drive(1'b0, 1'b0, 8'h0, 1'b1);

        // Partial frame discarded by rst; a full fresh frame is needed afterwards.
        fill(3, 8'h30);
        drive(1'b1, 1'b0, 8'h0, 1'b0);
        fill(FL - 1, 8'h50);
        drive(1'b0, 1'b0, 8'h0, 1'b0);
        chk("part_no_start", {31'd0, o_start}, 32'd0);
        chk("part_ready", {31'd0, o_ready}, 32'd1);
        fill(1, 8'h60);
        drive(1'b0, 1'b0, 8'h0, 1'b0);
        chk("part_start", {31'd0, o_start}, 32'd1);
        drive(1'b0, 1'b0, 8'h0, 1'b0);
        chk("wait_busy", {31'd0, o_busy}, 32'd1);
        drive(1'b1, 1'b0, 8'h0, 1'b0);
        drive(1'b0, 1'b0, 8'h0, 1'b0);
        chk("wrst_ready", {31'd0, o_ready}, 32'd1);
        chk("wrst_busy", {31'd0, o_busy}, 32'd0);
        chk("wrst_start", {31'd0, o_start}, 32'd0);

        // Gapped valid pattern 1,0,1,1,0,1,1.
        writes = 0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, (i != 1 && i != 4), DW'(i), 1'b0);
            chk("gap_no_start", {31'd0, o_start}, 32'd0);
            writes += int'(o_write_enable);
        end
        chk("gap_writes", 32'(writes), 32'd5);
        drive(1'b0, 1'b0, 8'h0, 1'b0);
        chk("gap_start", {31'd0, o_start}, 32'd1);
        drive(1'b0, 1'b0, 8'h0, 1'b1);

        drive(1'b1, 1'b0, 8'h0, 1'b0);
        for (int i = 0; i < 3; i++) frame();
        drive(1'b0, 1'b0, 8'h0, 1'b0);
        chk("frames_ready", {31'd0, o_ready}, 32'd1);
`ifdef INP_LOADER_FRAME_COUNT_EN
        chk("frame_count_3", {16'd0, o_frame_count}, 32'd3);
        drive(1'b1, 1'b0, 8'h0, 1'b0);
        drive(1'b0, 1'b0, 8'h0, 1'b0);
        chk("frame_count_rst", {16'd0, o_frame_count}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
